// File: rtl/q2_pkg.sv
// Q2 sequencer shared definitions: state codes, phase encoding and the
// ALU-op predicate also used by q2_control.
package q2_pkg;

  localparam logic [3:0] Q2_ST_FETCH = 4'd0;
  localparam logic [3:0] Q2_ST_LOAD  = 4'd1;
  localparam logic [3:0] Q2_ST_DEREF = 4'd2;
  localparam logic [3:0] Q2_ST_EXEC  = 4'd3;
  localparam logic [3:0] Q2_ST_ALU0  = 4'd4;

  typedef enum logic [1:0] {
    Q2_PH_SETUP  = 2'd0,
    Q2_PH_STROBE = 2'd1,
    Q2_PH_HOLD   = 2'd2
  } q2_phase_e;

  // True when the opcode needs the bit-serial ALU pass after exec.
  function automatic logic q2_is_alu_op(input logic op3, input logic op4,
                                        input logic op5);
    return (~op3 & ~op4) | ~op5;
  endfunction

endpackage

// File: rtl/q2_edge_detect.sv
// Rising-edge detector for a debounced level input.
// The history register resets to 1 so a level already high at reset
// does not register as an edge.
module q2_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  // Track the previous input level.
  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b1;
    else     r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/q2_sequencer.sv
// Q2 CPU sequencer: steps each instruction through fetch, optional load,
// optional deref, exec and an optional serial ALU pass, producing the
// state code and a one-clock write strobe per state. Also implements
// front-panel run / halt / single-step.
module q2_sequencer
  import q2_pkg::*;
#(
  parameter int unsigned ALU_STEPS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic op2,
  input  logic op3,
  input  logic op4,
  input  logic op5,
  input  logic run_sw,
  input  logic step_sw,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic ws,
  output logic halted
);

  localparam logic [3:0] LP_LAST = 4'(32'(Q2_ST_ALU0) + ALU_STEPS - 32'd1);

  logic [3:0] r_state;
  q2_phase_e  r_phase;
  logic       r_ws;
  logic       r_halted;
  logic       r_step_pend;
  logic [3:0] w_next;
  logic       w_step_rise;

  q2_edge_detect u_step_edge (
    .clk    (clk),
    .rst    (rst),
    .i_d    (step_sw),
    .o_rise (w_step_rise)
  );

  // Successor state, valid in the last phase of the current state.
  always_comb begin
    w_next = Q2_ST_FETCH;
    if (r_state == Q2_ST_FETCH)
      w_next = ~op5 ? Q2_ST_LOAD : (op2 ? Q2_ST_DEREF : Q2_ST_EXEC);
    else if (r_state == Q2_ST_LOAD)
      w_next = op2 ? Q2_ST_DEREF : Q2_ST_EXEC;
    else if (r_state == Q2_ST_DEREF)
      w_next = Q2_ST_EXEC;
    else if (r_state == Q2_ST_EXEC)
      w_next = q2_is_alu_op(op3, op4, op5) ? Q2_ST_ALU0 : Q2_ST_FETCH;
    else if (r_state < LP_LAST)
      w_next = r_state + 4'd1;
    else
      w_next = Q2_ST_FETCH;
  end

  // State/phase sequencing, write strobe, halt and step handling.
  // A step edge seen while halted is first captured in r_step_pend and
  // releases halt on the following clock; run releases halt directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= Q2_ST_FETCH;
      r_phase     <= Q2_PH_SETUP;
      r_ws        <= 1'b0;
      r_halted    <= 1'b1;
      r_step_pend <= 1'b0;
    end else if (r_state > LP_LAST) begin
      r_state <= Q2_ST_FETCH;
      r_phase <= Q2_PH_SETUP;
      r_ws    <= 1'b0;
    end else if (r_halted) begin
      r_phase <= Q2_PH_SETUP;
      r_ws    <= 1'b0;
      if (run_sw || r_step_pend) begin
        r_halted    <= 1'b0;
        r_step_pend <= 1'b0;
      end else begin
        r_step_pend <= w_step_rise;
      end
    end else begin
      case (r_phase)
        Q2_PH_SETUP: begin
          r_phase <= Q2_PH_STROBE;
          r_ws    <= 1'b1;
        end
        Q2_PH_STROBE: begin
          r_ws <= 1'b0;
          if (r_state == Q2_ST_FETCH) begin
            r_phase <= Q2_PH_HOLD;
          end else begin
            r_phase <= Q2_PH_SETUP;
            r_state <= w_next;
            if (w_next == Q2_ST_FETCH) r_halted <= ~run_sw;
          end
        end
        Q2_PH_HOLD: begin
          r_ws    <= 1'b0;
          r_phase <= Q2_PH_SETUP;
          r_state <= w_next;
        end
        default: begin
          r_ws    <= 1'b0;
          r_phase <= Q2_PH_SETUP;
        end
      endcase
    end
  end

  assign {s3, s2, s1, s0} = r_state;
  assign ws     = r_ws;
  assign halted = r_halted;

endmodule

// File: tb/tb_q2_sequencer.sv
// Directed bench for q2_sequencer: cycle-by-cycle vector table plus
// hand-written reset corner cases.
module tb_q2_sequencer;

  logic clk = 1'b0;
  logic rst, op2, op3, op4, op5, run_sw, step_sw;
  logic s0, s1, s2, s3, ws, halted;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // op nibble = {op5, op4, op3, op2}
  localparam logic [3:0] JMP = 4'b1100;
  localparam logic [3:0] ALD = 4'b0001;

  typedef struct {
    logic       rst;
    logic       run;
    logic       step;
    logic [3:0] op;
    logic [3:0] st;
    logic       ws;
    logic       h;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  q2_sequencer #(.ALU_STEPS(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .op2     (op2),
    .op3     (op3),
    .op4     (op4),
    .op5     (op5),
    .run_sw  (run_sw),
    .step_sw (step_sw),
    .s0      (s0),
    .s1      (s1),
    .s2      (s2),
    .s3      (s3),
    .ws      (ws),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic run, input logic stp,
                     input logic [3:0] op, input logic [3:0] st,
                     input logic w, input logic h, input string nm);
    vec_t v;
    v.rst = r; v.run = run; v.step = stp; v.op = op;
    v.st = st; v.ws = w; v.h = h; v.nm = nm;
    vecs.push_back(v);
  endtask

  // One non-fetch state: SETUP clock then STROBE clock.
  task automatic add_pair(input logic run_a, input logic run_b,
                          input logic [3:0] op, input logic [3:0] st,
                          input string nm);
    add(1'b0, run_a, 1'b0, op, st, 1'b0, 1'b0, nm);
    add(1'b0, run_b, 1'b0, op, st, 1'b1, 1'b0, nm);
  endtask

  task automatic drive(input logic r, input logic run, input logic stp,
                       input logic [3:0] op);
    rst = r; run_sw = run; step_sw = stp;
    {op5, op4, op3, op2} = op;
  endtask

  task automatic chk(input string nm, input logic [3:0] est,
                     input logic ews, input logic eh);
    n_vec++;
    if ({s3, s2, s1, s0} !== est || ws !== ews || halted !== eh) begin
      n_bad++;
      $display("FAIL %s: got st=%0d ws=%b halted=%b, want st=%0d ws=%b halted=%b",
               nm, {s3, s2, s1, s0}, ws, halted, est, ews, eh);
    end
  endtask

  initial begin
    bit found;
    // Reset with run high, then a free-running jump, twice.
    repeat (3) add(1'b1, 1'b1, 1'b0, JMP, 4'd0, 1'b0, 1'b1, "reset");
    add(1'b0, 1'b1, 1'b0, JMP, 4'd0, 1'b0, 1'b0, "release_unhalt");
    add(1'b0, 1'b1, 1'b0, JMP, 4'd0, 1'b1, 1'b0, "fetch_strobe");
    add(1'b0, 1'b1, 1'b0, JMP, 4'd0, 1'b0, 1'b0, "fetch_hold");
    add_pair(1'b1, 1'b1, JMP, 4'd3, "jmp_exec");
    add(1'b0, 1'b1, 1'b0, JMP, 4'd0, 1'b0, 1'b0, "jmp2_setup");
    add(1'b0, 1'b1, 1'b0, JMP, 4'd0, 1'b1, 1'b0, "jmp2_strobe");
    add(1'b0, 1'b1, 1'b0, JMP, 4'd0, 1'b0, 1'b0, "jmp2_hold");
    add_pair(1'b1, 1'b1, JMP, 4'd3, "jmp2_exec");
    // ALU with load and deref; op changes after the boundary clock.
    add(1'b0, 1'b1, 1'b0, JMP, 4'd0, 1'b0, 1'b0, "ald_setup");
    add(1'b0, 1'b1, 1'b0, ALD, 4'd0, 1'b1, 1'b0, "ald_strobe");
    add(1'b0, 1'b1, 1'b0, ALD, 4'd0, 1'b0, 1'b0, "ald_hold");
    for (int n = 1; n <= 11; n++) add_pair(1'b1, 1'b1, ALD, 4'(n), "ald_state");
    // Same instruction again, run dropped during alu state 6.
    add(1'b0, 1'b1, 1'b0, ALD, 4'd0, 1'b0, 1'b0, "drop_setup");
    add(1'b0, 1'b1, 1'b0, ALD, 4'd0, 1'b1, 1'b0, "drop_strobe");
    add(1'b0, 1'b1, 1'b0, ALD, 4'd0, 1'b0, 1'b0, "drop_hold");
    for (int n = 1; n <= 5; n++) add_pair(1'b1, 1'b1, ALD, 4'(n), "drop_state");
    add_pair(1'b1, 1'b0, ALD, 4'd6, "drop_state6");
    for (int n = 7; n <= 11; n++) add_pair(1'b0, 1'b0, ALD, 4'(n), "drop_finish");
    add(1'b0, 1'b0, 1'b0, ALD, 4'd0, 1'b0, 1'b1, "drop_halt");
    add(1'b0, 1'b0, 1'b0, ALD, 4'd0, 1'b0, 1'b1, "drop_idle");
    // Single step with a jump; further rises during the step are ignored.
    add(1'b0, 1'b0, 1'b1, JMP, 4'd0, 1'b0, 1'b1, "step_capture");
    add(1'b0, 1'b0, 1'b1, JMP, 4'd0, 1'b0, 1'b0, "step_unhalt");
    add(1'b0, 1'b0, 1'b0, JMP, 4'd0, 1'b1, 1'b0, "step_strobe");
    add(1'b0, 1'b0, 1'b1, JMP, 4'd0, 1'b0, 1'b0, "step_hold_rise");
    add(1'b0, 1'b0, 1'b0, JMP, 4'd3, 1'b0, 1'b0, "step_exec_setup");
    add(1'b0, 1'b0, 1'b1, JMP, 4'd3, 1'b1, 1'b0, "step_exec_rise");
    add(1'b0, 1'b0, 1'b0, JMP, 4'd0, 1'b0, 1'b1, "step_done");
    repeat (3) add(1'b0, 1'b0, 1'b0, JMP, 4'd0, 1'b0, 1'b1, "step_no_queue");

    drive(1'b1, 1'b0, 1'b0, JMP);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].run, vecs[i].step, vecs[i].op);
      @(posedge clk); #1;
      chk(vecs[i].nm, vecs[i].st, vecs[i].ws, vecs[i].h);
    end

    // Reset in alu state 8 STROBE.
    drive(1'b0, 1'b1, 1'b0, ALD);
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(posedge clk); #1;
      if ({s3, s2, s1, s0} == 4'd8 && ws) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_bad++;
      $display("FAIL alu8_reach: got no state 8 strobe within 80 clocks, want one");
    end
    drive(1'b1, 1'b1, 1'b0, ALD);
    @(posedge clk); #1;
    chk("rst_mid_alu", 4'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, ALD);
    @(posedge clk); #1;
    chk("rst_mid_alu_unhalt", 4'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rst_mid_alu_strobe", 4'd0, 1'b1, 1'b0);

    // Step switch already high across reset must not step.
    drive(1'b1, 1'b0, 1'b1, JMP);
    @(posedge clk); #1;
    chk("rst_step_high", 4'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, JMP);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("step_held_no_edge", 4'd0, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
